// File: rtl/uart_pkg.sv
// uart_pkg
// Definitions shared by the UART blocks (uart_rx today, uart_tx later).
//   OVERSAMPLE   : ticks per bit period
//   DATA_BITS    : payload bits per character (8N1 framing)
//   uart_state_t : receive FSM state encoding
package uart_pkg;

    localparam int OVERSAMPLE = 16;
    localparam int DATA_BITS  = 8;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_STOP,
        UART_WAIT_HIGH
    } uart_state_t;

endpackage

// File: rtl/uart_fifo.sv
// uart_fifo
// First-word-fall-through FIFO. The head entry is always visible on
// head_data, and a pop simply advances past it.
//   clk, rst_n : clock, asynchronous active-low reset
//   push       : write push_data. Ignored when full, unless a pop also happens
//                in the same cycle.
//   pop        : discard the head entry. Ignored when empty.
//   head_data  : oldest entry; meaningful only while !empty
//   full/empty : occupancy flags
//   count      : number of stored entries (0 .. 2**AW)
module uart_fifo #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      count
);

    localparam int DEPTH = 2 ** AW;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign head_data = mem[rd_ptr];

    // A pop frees a slot in the same cycle, so a push into a full FIFO is
    // accepted when it coincides with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    // Storage, pointers and occupancy. The storage is cleared on reset so the
    // head output reads 0 instead of stale data after a reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx.sv
// uart_rx
// 8N1 serial receiver with 16x oversampling and a small FWFT output FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   rx         : raw serial line (asynchronous, idle high)
//   rx_data    : byte at the FIFO head, valid while rx_valid
//   rx_valid   : FIFO not empty
//   rx_ready   : consumer takes the head byte when rx_valid && rx_ready
//   frame_err  : one-cycle pulse when a stop bit is sampled low
//   overrun    : one-cycle pulse when a good byte is dropped because the FIFO is full
module uart_rx
    import uart_pkg::*;
#(
    parameter int SYS_CLK_FREQ = 100_000_000,
    parameter int BAUD_RATE    = 115200,
    parameter int FIFO_AW      = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       frame_err,
    output logic       overrun
);

    // DIV must come out as at least 1 for the chosen clock and baud rate.
    localparam int DIV        = SYS_CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int DIV_W      = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int TICK_W     = $clog2(OVERSAMPLE);
    localparam int BIT_W      = $clog2(DATA_BITS);
    localparam int FIFO_DEPTH = 2 ** FIFO_AW;

    logic                 rx_meta;
    logic                 rxs;
    logic [DIV_W-1:0]     div_cnt;
    logic                 tick;
    uart_state_t          state;
    logic [TICK_W-1:0]    tick_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;

    logic                 stop_sample;
    logic                 good_byte;
    logic                 drop_byte;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FIFO_AW:0]     fifo_count;

    // Two-flop synchronizer. Both stages reset high so that reset never
    // looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta <= 1'b1;
            rxs     <= 1'b1;
        end else begin
            rx_meta <= rx;
            rxs     <= rx_meta;
        end
    end

    // Oversampling tick divider. It restarts on start detection so that tick
    // phase is aligned to the falling edge of the start bit.
    assign tick = (div_cnt == DIV_W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
        end else if (state == UART_IDLE && !rxs) begin
            div_cnt <= '0;
        end else if (tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + 1'b1;
        end
    end

    // The stop bit is sampled on the last tick of its bit period. A good stop
    // bit produces a byte. If the FIFO is full and nothing is popped in the
    // same cycle, that byte is dropped.
    assign stop_sample = (state == UART_STOP) && tick && (tick_cnt == TICK_W'(OVERSAMPLE - 1));
    assign good_byte   = stop_sample && rxs;
    assign fifo_pop    = rx_valid && rx_ready;
    assign fifo_push   = good_byte && (!fifo_full || fifo_pop);
    assign drop_byte   = good_byte && (fifo_count == (FIFO_AW+1)'(FIFO_DEPTH)) && !fifo_pop;

    // Receive FSM.
    // The start bit is checked at mid-bit (half an oversample period) to
    // reject glitches. From there, every full oversample period lands in the
    // middle of the next bit. A low stop bit parks the FSM in WAIT_HIGH until
    // the line recovers, so a held-low break reports exactly one error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= UART_IDLE;
            tick_cnt  <= '0;
            bit_cnt   <= '0;
            shift_reg <= '0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            overrun   <= drop_byte;
            case (state)
                UART_IDLE: begin
                    if (!rxs) begin
                        tick_cnt <= '0;
                        state    <= UART_START;
                    end
                end
                UART_START: begin
                    if (tick) begin
                        if (tick_cnt == TICK_W'(OVERSAMPLE / 2 - 1)) begin
                            if (rxs) begin
                                state <= UART_IDLE;
                            end else begin
                                tick_cnt <= '0;
                                bit_cnt  <= '0;
                                state    <= UART_DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + 1'b1;
                        end
                    end
                end
                UART_DATA: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                        if (tick_cnt == TICK_W'(OVERSAMPLE - 1)) begin
                            shift_reg <= {rxs, shift_reg[DATA_BITS-1:1]};
                            bit_cnt   <= bit_cnt + 1'b1;
                            if (bit_cnt == BIT_W'(DATA_BITS - 1)) begin
                                state <= UART_STOP;
                            end
                        end
                    end
                end
                UART_STOP: begin
                    if (tick) begin
                        tick_cnt <= tick_cnt + 1'b1;
                    end
                    if (stop_sample) begin
                        if (rxs) begin
                            state <= UART_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state     <= UART_WAIT_HIGH;
                        end
                    end
                end
                UART_WAIT_HIGH: begin
                    if (rxs) begin
                        state <= UART_IDLE;
                    end
                end
                default: begin
                    state <= UART_IDLE;
                end
            endcase
        end
    end

    assign rx_valid = !fifo_empty;

    uart_fifo #(
        .WIDTH (DATA_BITS),
        .AW    (FIFO_AW)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (shift_reg),
        .pop       (fifo_pop),
        .head_data (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx
// Directed bench for uart_rx. The clock is 64x the baud rate, which gives
// DIV = 4 and 64 clocks per bit. Inputs are driven 1 ns after the rising edge.
// Outputs are sampled on the falling edge.
module tb_uart_rx;

    localparam int BAUD    = 1_000_000;
    localparam int CLKF    = 64 * BAUD;
    localparam int BIT_CYC = 64;
    // The stop sample lands 611 cycles after the start-bit falling edge is driven.
    localparam int STOP_LAT = 611;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       rx_ready = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       frame_err;
    logic       overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int valid_cnt = 0;
    int last_start = 0;

    logic [7:0] got_data[$];
    int         got_cyc[$];
    int         fe_cyc[$];
    int         ov_cyc[$];

    uart_rx #(
        .SYS_CLK_FREQ (CLKF),
        .BAUD_RATE    (BAUD),
        .FIFO_AW      (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Free-running cycle counter used for latency measurements.
    always @(posedge clk) cyc <= cyc + 1;

    // Event log: handshakes, valid cycles, error pulses, each with its cycle stamp.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_cnt <= valid_cnt + 1;
            if (rx_valid && rx_ready) begin
                got_data.push_back(rx_data);
                got_cyc.push_back(cyc);
            end
            if (frame_err) fe_cyc.push_back(cyc);
            if (overrun) ov_cyc.push_back(cyc);
        end
    end

    task automatic clear_log();
        got_data.delete();
        got_cyc.delete();
        fe_cyc.delete();
        ov_cyc.delete();
    endtask

    // Drives one 8N1 frame and ends after the stop bit period.
    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx = 1'b0;
        last_start = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (BIT_CYC) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (BIT_CYC) @(posedge clk);
        #1 rx = 1'b1;
        repeat (BIT_CYC) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx = 1'b1;
        rx_ready = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL reset_rx_data: got 0x%02h expected 0x00", rx_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
        @(posedge clk); #1 rst_n = 1'b1;
        repeat (10) @(posedge clk);
        #1;
    endtask

    task automatic test_single_byte();
        int base;
        rx_ready = 1'b1;
        clear_log();
        base = valid_cnt;
        send_byte(8'hA5);
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (got_data.size() != 1) begin n_fail++; $display("[TB] FAIL single_count: got %0d bytes expected 1", got_data.size()); end
        n_checks++;
        if (got_data.size() < 1 || got_data[0] !== 8'hA5) begin
            n_fail++; $display("[TB] FAIL single_data: got 0x%02h expected 0xa5", (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
        n_checks++;
        if (got_cyc.size() < 1 || (got_cyc[0] - last_start) < STOP_LAT - 1 || (got_cyc[0] - last_start) > STOP_LAT + 1) begin
            n_fail++; $display("[TB] FAIL single_latency: got %0d cycles expected %0d+-1", (got_cyc.size() > 0) ? got_cyc[0] - last_start : -1, STOP_LAT);
        end
        n_checks++; if (valid_cnt - base != 1) begin n_fail++; $display("[TB] FAIL single_valid_width: got %0d cycles expected 1", valid_cnt - base); end
        n_checks++; if (fe_cyc.size() != 0) begin n_fail++; $display("[TB] FAIL single_frame_err: got %0d pulses expected 0", fe_cyc.size()); end
    endtask

    task automatic test_glitch();
        int base;
        rx_ready = 1'b1;
        clear_log();
        base = valid_cnt;
        @(posedge clk); #1 rx = 1'b0;
        repeat (20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (200) @(posedge clk);
        #1;
        n_checks++; if (valid_cnt - base != 0) begin n_fail++; $display("[TB] FAIL glitch_valid: got %0d valid cycles expected 0", valid_cnt - base); end
        n_checks++; if (fe_cyc.size() != 0) begin n_fail++; $display("[TB] FAIL glitch_frame_err: got %0d pulses expected 0", fe_cyc.size()); end
        send_byte(8'h5A);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h5A) begin
            n_fail++; $display("[TB] FAIL glitch_recover: got %0d bytes first 0x%02h expected 1 byte 0x5a", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
    endtask

    task automatic test_fill_overrun();
        rx_ready = 1'b0;
        clear_log();
        for (int v = 1; v <= 5; v++) begin
            send_byte(8'(v));
        end
        repeat (20) @(posedge clk);
        #1;
        n_checks++; if (ov_cyc.size() != 1) begin n_fail++; $display("[TB] FAIL fill_overrun_count: got %0d pulses expected 1", ov_cyc.size()); end
        n_checks++;
        if (ov_cyc.size() < 1 || (ov_cyc[0] - last_start) < STOP_LAT - 1 || (ov_cyc[0] - last_start) > STOP_LAT + 1) begin
            n_fail++; $display("[TB] FAIL fill_overrun_when: got %0d cycles into byte 5 expected %0d+-1", (ov_cyc.size() > 0) ? ov_cyc[0] - last_start : -1, STOP_LAT);
        end
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== 8'(i + 1)) begin
                n_fail++; $display("[TB] FAIL fill_drain_%0d: got valid %b data 0x%02h expected valid 1 data 0x%02h", i, rx_valid, rx_data, 8'(i + 1));
            end
        end
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fill_drain_empty: got valid %b expected 0", rx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_break();
        int rel;
        int base;
        rx_ready = 1'b1;
        rx = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        rel = cyc;
        clear_log();
        base = valid_cnt;
        repeat (700) @(posedge clk);
        #1;
        n_checks++; if (fe_cyc.size() != 1) begin n_fail++; $display("[TB] FAIL break_frame_err_count: got %0d pulses expected 1", fe_cyc.size()); end
        n_checks++;
        if (fe_cyc.size() < 1 || (fe_cyc[0] - rel) < STOP_LAT - 1 || (fe_cyc[0] - rel) > STOP_LAT + 1) begin
            n_fail++; $display("[TB] FAIL break_frame_err_when: got %0d cycles expected %0d+-1", (fe_cyc.size() > 0) ? fe_cyc[0] - rel : -1, STOP_LAT);
        end
        repeat (2000) @(posedge clk);
        #1;
        n_checks++; if (fe_cyc.size() != 1) begin n_fail++; $display("[TB] FAIL break_held_low: got %0d pulses expected 1", fe_cyc.size()); end
        n_checks++; if (valid_cnt - base != 0) begin n_fail++; $display("[TB] FAIL break_no_valid: got %0d valid cycles expected 0", valid_cnt - base); end
        rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        send_byte(8'h3C);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h3C) begin
            n_fail++; $display("[TB] FAIL break_recover: got %0d bytes first 0x%02h expected 1 byte 0x3c", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
    endtask

    task automatic test_full_simultaneous_pop();
        logic [7:0] exp_q[4];
        exp_q[0] = 8'h22; exp_q[1] = 8'h33; exp_q[2] = 8'h44; exp_q[3] = 8'h55;
        rx_ready = 1'b0;
        clear_log();
        send_byte(8'h11);
        send_byte(8'h22);
        send_byte(8'h33);
        send_byte(8'h44);
        fork
            send_byte(8'h55);
            begin
                @(posedge clk);
                repeat (STOP_LAT - 1) @(posedge clk);
                #1 rx_ready = 1'b1;
                @(posedge clk);
                #1 rx_ready = 1'b0;
            end
        join
        repeat (5) @(posedge clk);
        #1;
        n_checks++; if (ov_cyc.size() != 0) begin n_fail++; $display("[TB] FAIL fullpop_overrun: got %0d pulses expected 0", ov_cyc.size()); end
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h11) begin
            n_fail++; $display("[TB] FAIL fullpop_popped: got %0d bytes first 0x%02h expected 1 byte 0x11", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
        rx_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (rx_valid !== 1'b1 || rx_data !== exp_q[i]) begin
                n_fail++; $display("[TB] FAIL fullpop_drain_%0d: got valid %b data 0x%02h expected valid 1 data 0x%02h", i, rx_valid, rx_data, exp_q[i]);
            end
        end
        @(negedge clk);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL fullpop_empty: got valid %b expected 0", rx_valid); end
        @(posedge clk); #1;
    endtask

    task automatic test_reset_mid_frame();
        logic [7:0] b;
        b = 8'h99;
        rx_ready = 1'b0;
        clear_log();
        send_byte(8'h12);
        repeat (10) @(posedge clk);
        #1;
        n_checks++; if (rx_valid !== 1'b1 || rx_data !== 8'h12) begin n_fail++; $display("[TB] FAIL midreset_prefill: got valid %b data 0x%02h expected valid 1 data 0x12", rx_valid, rx_data); end
        @(posedge clk); #1 rx = 1'b0;
        for (int i = 0; i < 3; i++) begin
            repeat (BIT_CYC) @(posedge clk);
            #1 rx = b[i];
        end
        repeat (BIT_CYC) @(posedge clk);
        #1 rx = b[3];
        repeat (BIT_CYC / 2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL midreset_rx_data: got 0x%02h expected 0x00", rx_data); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_frame_err: got %b expected 0", frame_err); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("[TB] FAIL midreset_overrun: got %b expected 0", overrun); end
        rx = 1'b1;
        repeat (4) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        clear_log();
        rx_ready = 1'b1;
        send_byte(8'h7E);
        repeat (20) @(posedge clk);
        #1;
        n_checks++;
        if (got_data.size() != 1 || got_data[0] !== 8'h7E) begin
            n_fail++; $display("[TB] FAIL midreset_recover: got %0d bytes first 0x%02h expected 1 byte 0x7e", got_data.size(), (got_data.size() > 0) ? got_data[0] : 8'hxx);
        end
        n_checks++; if (fe_cyc.size() != 0) begin n_fail++; $display("[TB] FAIL midreset_frame_err_after: got %0d pulses expected 0", fe_cyc.size()); end
    endtask

    initial begin
        $display("[TB] uart_rx bench start");
        test_reset();
        test_single_byte();
        test_glitch();
        test_fill_overrun();
        test_break();
        test_full_simultaneous_pop();
        test_reset_mid_frame();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

Serial receive front end for the CPU's host interface. It oversamples the asynchronous `Rx` pin at 16× the baud rate and frames 8N1 characters. Received bytes go into a small first-word-fall-through FIFO, which the downstream host-controller consumes through a valid/ready handshake. The block sits between the board `Rx` pin and the CPU-side byte consumer inside `riscv_top`.

## Interface
- `SYS_CLK_FREQ`, default 100_000_000: `clk` frequency in Hz.
- `BAUD_RATE`, default 115200: line rate in bit/s.
- `FIFO_AW`, default 2: FIFO address width; depth is 2**FIFO_AW.
- `clk`  input  1: sole clock; all state updates on its rising edge.
- `rst_n`  input  1: asynchronous, active-low reset.
- `rx`  input  1: raw serial line, asynchronous to `clk`, idle high.
- `rx_data`  output  8: byte at the FIFO head; valid only while `rx_valid` is 1.
- `rx_valid`  output  1: FIFO is non-empty.
- `rx_ready`  input  1: consumer accepts the head byte when `rx_valid && rx_ready`.
- `frame_err`  output  1: one-cycle pulse when a stop bit is sampled low.
- `overrun`  output  1: one-cycle pulse when a good byte is dropped because the FIFO is full.

## Operation
- Synchronizer: 2 flops on `rx`, both reset to 1. All logic below uses the synchronized value `rxs`.
- Tick divider: `DIV = SYS_CLK_FREQ / (BAUD_RATE*16)`, integer floor, must be ≥ 1.
  - Counter runs 0..DIV-1; `tick` is asserted when the counter equals DIV-1.
  - The counter is cleared on start detection in IDLE.
- FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. Reset state is IDLE.
- IDLE: `rxs == 0` → clear the divider and the tick count, go to START.
- START: on the 8th tick (mid start bit), sample `rxs`.
  - 1 → false start, return to IDLE.
  - 0 → clear the tick count, go to DATA.
- DATA: every 16th tick, sample `rxs` into the shift register, LSB first. After the 8th bit, go to STOP.
- STOP: on the 16th tick, sample `rxs`.
  - 1 → push the byte, go to IDLE.
  - 0 → pulse `frame_err`, drop the byte, go to WAIT_HIGH.
- WAIT_HIGH: stay until `rxs == 1`, then go to IDLE. This prevents a held-low line (break) from re-triggering.
- FIFO:
  - Push when the stop bit is good and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - Otherwise pulse `overrun` and discard the byte.
  - Pop on `rx_valid && rx_ready`.
  - Push and pop in the same cycle leaves the count unchanged.
  - Pointers wrap modulo 2**FIFO_AW. The count is FIFO_AW+1 bits wide.
- Reset mid-frame abandons the character. FIFO contents are discarded, pointers and count go to 0.

## Timing
- Reset values: `rx_valid` 0, `rx_data` 0, `frame_err` 0, `overrun` 0. Shift register, pointers, count, divider and tick count are all 0.
- Detection: an `rx` falling edge reaches the FSM 2 cycles later (synchronizer delay), then IDLE→START takes 1 cycle.
- Sample points: bit n is sampled at (8 + 16·(n+1))·DIV cycles after start detection, ±1 cycle. Data bits are n = 0..7; the stop bit is n = 8.
- Push latency: the byte appears on `rx_data` with `rx_valid` = 1 on the cycle after the stop-bit sample.
- Pop latency: `rx_data` shows the next entry on the cycle after the pop. `rx_valid` drops the cycle after the last pop.
- `frame_err` and `overrun` are registered pulses, asserted the cycle after the stop-bit sample.

## Structure
- Shared package `uart_pkg`: FSM state encoding (`UART_IDLE`, `UART_START`, `UART_DATA`, `UART_STOP`, `UART_WAIT_HIGH`) and the constants `OVERSAMPLE = 16` and `DATA_BITS = 8`. These are reused by the planned `uart_tx`.
- One sub-module: `uart_fifo`, a parameterized FWFT FIFO (width 8, depth 2**FIFO_AW) with push, pop, full, empty and count.
- Everything else lives in `uart_rx`.

## Test plan
All scenarios use `SYS_CLK_FREQ = 64*BAUD_RATE`, giving DIV = 4 and 64 clocks/bit.
- Single byte: send 0xA5 as 8N1 with `rx_ready` = 1.
  - `rx_valid` pulses for exactly 1 cycle with `rx_data` = 0xA5.
  - It fires 1 cycle after the stop sample, at 9.5 bits + 3 cycles from the falling edge, ±1.
- Glitch: drive `rx` low for 20 clocks, then high → no `rx_valid`, no `frame_err`, FSM back in IDLE.
- Fill and overrun: with `rx_ready` = 0, send 0x01..0x05.
  - The FIFO holds 0x01..0x04.
  - `overrun` pulses once, on byte 0x05.
  - Raising `rx_ready` then yields 0x01, 0x02, 0x03, 0x04 on consecutive cycles.
- Break (line held at 0 after reset):
  - One `frame_err` pulse at about 9.5 bit times.
  - No further pulses and no `rx_valid` while the line stays at 0.
  - Releasing to 1 and then sending 0x3C yields 0x3C.
- Full with simultaneous pop: FIFO full, `rx_ready` = 1 on the cycle a new byte pushes → no `overrun`, count stays 4, byte order preserved.
- Reset mid-frame: assert `rst_n` = 0 during DATA bit 3.
  - All outputs go to their reset values immediately.
  - After release, the next full frame 0x7E is received correctly.
